// File: rtl/fft8.sv
// Unscaled 8-point forward DFT (radix-2 DIT, twiddle c = 181/256), one transform per cycle.
// Latency 1 cycle from the sampling edge to registered outputs; no backpressure, accepts every cycle.
module fft8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] dinre,
  input  logic [79:0] dinim,
  output logic [79:0] doutre,
  output logic [79:0] doutim
);

  // Sums reach ~1.3M after x256 scaling; 24 signed bits leave margin.
  localparam int W = 24;
  localparam logic signed [W-1:0] RND  = 255;
  localparam logic signed [W-1:0] ZRO  = 0;
  localparam logic signed [W-1:0] COEF = 181;

  logic signed [W-1:0] xr [8];
  logic signed [W-1:0] xi [8];
  logic signed [W-1:0] ar [4];
  logic signed [W-1:0] ai [4];
  logic signed [W-1:0] br [4];
  logic signed [W-1:0] bi [4];
  logic signed [W-1:0] tr [4];
  logic signed [W-1:0] ti [4];
  logic signed [W-1:0] sr [8];
  logic signed [W-1:0] si [8];
  logic [79:0] nxtre;
  logic [79:0] nxtim;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      xr[i] = W'($signed(dinre[10*i +: 10]));
      xi[i] = W'($signed(dinim[10*i +: 10]));
    end
  end

  // 4-point DFTs of even (A) and odd (B) samples; -j and +j are swaps.
  always_comb begin
    ar[0] = xr[0] + xr[2] + xr[4] + xr[6];
    ai[0] = xi[0] + xi[2] + xi[4] + xi[6];
    ar[1] = (xr[0] - xr[4]) + (xi[2] - xi[6]);
    ai[1] = (xi[0] - xi[4]) - (xr[2] - xr[6]);
    ar[2] = xr[0] - xr[2] + xr[4] - xr[6];
    ai[2] = xi[0] - xi[2] + xi[4] - xi[6];
    ar[3] = (xr[0] - xr[4]) - (xi[2] - xi[6]);
    ai[3] = (xi[0] - xi[4]) + (xr[2] - xr[6]);

    br[0] = xr[1] + xr[3] + xr[5] + xr[7];
    bi[0] = xi[1] + xi[3] + xi[5] + xi[7];
    br[1] = (xr[1] - xr[5]) + (xi[3] - xi[7]);
    bi[1] = (xi[1] - xi[5]) - (xr[3] - xr[7]);
    br[2] = xr[1] - xr[3] + xr[5] - xr[7];
    bi[2] = xi[1] - xi[3] + xi[5] - xi[7];
    br[3] = (xr[1] - xr[5]) - (xi[3] - xi[7]);
    bi[3] = (xi[1] - xi[5]) + (xr[3] - xr[7]);
  end

  // Twiddled odd terms, all scaled by 256 so the diagonal ones stay exact.
  always_comb begin
    tr[0] = br[0] <<< 8;
    ti[0] = bi[0] <<< 8;
    tr[1] = COEF * (br[1] + bi[1]);
    ti[1] = COEF * (bi[1] - br[1]);
    tr[2] = bi[2] <<< 8;
    ti[2] = -(br[2] <<< 8);
    tr[3] = COEF * (bi[3] - br[3]);
    ti[3] = -(COEF * (br[3] + bi[3]));
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sr[k]   = (ar[k] <<< 8) + tr[k];
      si[k]   = (ai[k] <<< 8) + ti[k];
      sr[k+4] = (ar[k] <<< 8) - tr[k];
      si[k+4] = (ai[k] <<< 8) - ti[k];
    end
  end

  // Biasing negatives by 255 before the arithmetic shift makes it truncate toward zero.
  always_comb begin
    nxtre = '0;
    nxtim = '0;
    for (int k = 0; k < 8; k++) begin
      nxtre[10*k +: 10] = 10'((sr[k] + (sr[k][W-1] ? RND : ZRO)) >>> 8);
      nxtim[10*k +: 10] = 10'((si[k] + (si[k][W-1] ? RND : ZRO)) >>> 8);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      doutre <= '0;
      doutim <= '0;
    end else begin
      doutre <= nxtre;
      doutim <= nxtim;
    end
  end

endmodule

// File: tb/tb_fft8.sv
// Bench for fft8: directed spec vectors plus random vectors against a direct DFT summation model.
module tb_fft8;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] dinre;
  logic [79:0] dinim;
  logic [79:0] doutre;
  logic [79:0] doutim;

  int checks = 0;
  int errors = 0;

  fft8 dut (
    .clk   (clk),
    .rst   (rst),
    .dinre (dinre),
    .dinim (dinim),
    .doutre(doutre),
    .doutim(doutim)
  );

  always #5 clk = ~clk;

  int mix_re[8]  = '{3, -13, -4, 3, 36, 28, -13, 30};
  int mix_im[8]  = '{7, -12, 7, 16, 5, 10, 7, -3};
  int mixo_re[8] = '{70, -45, 41, -25, -26, -20, 71, -40};
  int mixo_im[8] = '{37, 12, 16, 88, 15, -26, -20, -66};
  int imp_re[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
  int zero8[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
  int ones8[8]   = '{1, 1, 1, 1, 1, 1, 1, 1};
  int dly_re[8]  = '{0, 1, 0, 0, 0, 0, 0, 0};
  int dlyo_re[8] = '{1, 0, 0, 0, -1, 0, 0, 0};
  int dlyo_im[8] = '{0, 0, -1, 0, 0, 0, 1, 0};
  int dc_o[8]    = '{8, 0, 0, 0, 0, 0, 0, 0};
  int big8[8]    = '{511, 511, 511, 511, 511, 511, 511, 511};
  int big_o[8]   = '{-8, 0, 0, 0, 0, 0, 0, 0};

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] pk(input int v[8]);
    logic [79:0] r;
    int t;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = v[i];
      r[10*i +: 10] = t[9:0];
    end
    return r;
  endfunction

  // Twiddle W^m times 256, with the sqrt(2)/2 magnitude held as 181.
  function automatic int twr(input int m);
    case (m)
      0: return 256;  1: return 181;  2: return 0;    3: return -181;
      4: return -256; 5: return -181; 6: return 0;    default: return 181;
    endcase
  endfunction

  function automatic int twi(input int m);
    case (m)
      0: return 0;    1: return -181; 2: return -256; 3: return -181;
      4: return 0;    5: return 181;  6: return 256;  default: return 181;
    endcase
  endfunction

  // Direct O(N^2) DFT; integer '/' truncates toward zero, then wrap to 10 bits.
  task automatic ref_dft(input logic [79:0] xr, input logic [79:0] xi,
                         output logic [79:0] yr, output logic [79:0] yi);
    int a, b, sr, si, qr, qi, m;
    yr = '0;
    yi = '0;
    for (int k = 0; k < 8; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 8; n++) begin
        a = $signed(xr[10*n +: 10]);
        b = $signed(xi[10*n +: 10]);
        m = (n * k) % 8;
        sr += a * twr(m) - b * twi(m);
        si += a * twi(m) + b * twr(m);
      end
      qr = sr / 256;
      qi = si / 256;
      yr[10*k +: 10] = qr[9:0];
      yi[10*k +: 10] = qi[9:0];
    end
  endtask

  task automatic cyc(input logic r, input logic [79:0] re, input logic [79:0] im);
    @(negedge clk);
    rst   = r;
    dinre = re;
    dinim = im;
    @(posedge clk);
    #1;
  endtask

  logic [79:0] er, ei, vr, vi;

  initial begin
    rst   = 1'b1;
    dinre = '0;
    dinim = '0;

    cyc(1'b1, {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)});
    check("reset_re", doutre, '0);
    check("reset_im", doutim, '0);

    cyc(1'b1, pk(mix_re), pk(mix_im));
    check("rstprio_re", doutre, '0);
    check("rstprio_im", doutim, '0);

    cyc(1'b0, pk(mix_re), pk(mix_im));
    check("mix_re", doutre, pk(mixo_re));
    check("mix_im", doutim, pk(mixo_im));

    cyc(1'b0, pk(imp_re), pk(zero8));
    check("impulse_re", doutre, pk(ones8));
    check("impulse_im", doutim, pk(zero8));

    cyc(1'b0, pk(dly_re), pk(zero8));
    check("delayed_re", doutre, pk(dlyo_re));
    check("delayed_im", doutim, pk(dlyo_im));

    cyc(1'b0, pk(ones8), pk(zero8));
    check("dc_re", doutre, pk(dc_o));
    check("dc_im", doutim, pk(zero8));

    cyc(1'b0, pk(big8), pk(zero8));
    check("wrap_re", doutre, pk(big_o));
    check("wrap_im", doutim, pk(zero8));

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        cyc(1'b0, pk(mix_re), pk(mix_im));
        check("b2b_mix_re", doutre, pk(mixo_re));
        check("b2b_mix_im", doutim, pk(mixo_im));
      end else begin
        cyc(1'b0, pk(imp_re), pk(zero8));
        check("b2b_imp_re", doutre, pk(ones8));
        check("b2b_imp_im", doutim, pk(zero8));
      end
    end

    // Mid-stream reset: the transform in flight must not survive.
    cyc(1'b0, pk(mix_re), pk(mix_im));
    cyc(1'b1, pk(big8), pk(ones8));
    check("midrst_re", doutre, '0);
    check("midrst_im", doutim, '0);
    vr = {$urandom, $urandom, 16'($urandom)};
    vi = {$urandom, $urandom, 16'($urandom)};
    ref_dft(vr, vi, er, ei);
    cyc(1'b0, vr, vi);
    check("postrst_re", doutre, er);
    check("postrst_im", doutim, ei);

    for (int i = 0; i < 300; i++) begin
      vr = {$urandom, $urandom, 16'($urandom)};
      vi = {$urandom, $urandom, 16'($urandom)};
      ref_dft(vr, vi, er, ei);
      cyc(1'b0, vr, vi);
      check("rand_re", doutre, er);
      check("rand_im", doutim, ei);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
